lcd_write_sequencer: RTL and testbench



---
 rtl/lcd_write_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_lcd_write_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_write_sequencer.sv
// HD44780 8-bit write sequencer: power-on init ROM, then one request per write.
// Write latency is 1 + E_TICKS + hold ticks from acceptance. req_ready is high only in IDLE, and there is no request buffering.
module lcd_write_sequencer #(
  parameter int POWER_TICKS = 300,
  parameter int E_TICKS     = 1,
  parameter int CMD_TICKS   = 1,
  parameter int CLR_TICKS   = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data
);

  if (POWER_TICKS < 1 || POWER_TICKS > 65535) begin : g_bad_power_ticks
    $error("POWER_TICKS must be in 1..65535");
  end
  if (E_TICKS < 1 || E_TICKS > 65535) begin : g_bad_e_ticks
    $error("E_TICKS must be in 1..65535");
  end
  if (CMD_TICKS < 1 || CMD_TICKS > 65535) begin : g_bad_cmd_ticks
    $error("CMD_TICKS must be in 1..65535");
  end
  if (CLR_TICKS < 1 || CLR_TICKS > 65535) begin : g_bad_clr_ticks
    $error("CLR_TICKS must be in 1..65535");
  end

  localparam logic [15:0] POWER_LAST = 16'(POWER_TICKS - 1);
  localparam logic [15:0] E_LAST     = 16'(E_TICKS - 1);
  localparam logic [15:0] CMD_LAST   = 16'(CMD_TICKS - 1);
  localparam logic [15:0] CLR_LAST   = 16'(CLR_TICKS - 1);
  localparam logic [2:0]  INIT_LAST  = 3'd5;

  typedef enum logic [2:0] {
    PWR_WAIT,
    SETUP,
    E_HIGH,
    HOLD,
    IDLE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic        lcd_e_q, lcd_e_d;
  logic        lcd_rs_q, lcd_rs_d;
  logic [7:0]  lcd_data_q, lcd_data_d;
  logic        req_ready_q, req_ready_d;
  logic        init_done_q, init_done_d;

  logic [15:0] last_cnt;
  logic        step_done;
  logic        slow_cmd;

  function automatic logic [7:0] init_rom(input logic [2:0] i);
    logic [7:0] b;
    case (i)
      3'd3:    b = 8'h0C;
      3'd4:    b = 8'h01;
      3'd5:    b = 8'h06;
      default: b = 8'h38;
    endcase
    return b;
  endfunction

  // Clear display and return home need the long hold.
  assign slow_cmd = !lcd_rs_q &&
                    (lcd_data_q == 8'h01 || lcd_data_q == 8'h02 || lcd_data_q == 8'h03);

  always_comb begin
    last_cnt = 16'd0;
    case (state_q)
      PWR_WAIT: last_cnt = POWER_LAST;
      SETUP:    last_cnt = 16'd0;
      E_HIGH:   last_cnt = E_LAST;
      HOLD:     last_cnt = slow_cmd ? CLR_LAST : CMD_LAST;
      default:  last_cnt = 16'd0;
    endcase
  end

  assign step_done = tick && (cnt_q == last_cnt) && (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lcd_e_d     = lcd_e_q;
    lcd_rs_d    = lcd_rs_q;
    lcd_data_d  = lcd_data_q;
    req_ready_d = req_ready_q;
    init_done_d = init_done_q;

    case (state_q)
      PWR_WAIT: begin
        if (step_done) begin
          idx_d      = 3'd0;
          lcd_rs_d   = 1'b0;
          lcd_data_d = init_rom(3'd0);
          state_d    = SETUP;
        end
      end
      SETUP: begin
        if (step_done) begin
          lcd_e_d = 1'b1;
          state_d = E_HIGH;
        end
      end
      E_HIGH: begin
        if (step_done) begin
          lcd_e_d = 1'b0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (step_done) begin
          if (!init_done_q && idx_q != INIT_LAST) begin
            idx_d      = idx_q + 3'd1;
            lcd_rs_d   = 1'b0;
            lcd_data_d = init_rom(idx_q + 3'd1);
            state_d    = SETUP;
          end else begin
            init_done_d = 1'b1;
            req_ready_d = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      IDLE: begin
        if (req_valid && req_ready_q) begin
          lcd_rs_d    = req_rs;
          lcd_data_d  = req_data;
          req_ready_d = 1'b0;
          state_d     = SETUP;
        end
      end
      default: begin
        lcd_e_d     = 1'b0;
        req_ready_d = 1'b0;
        state_d     = PWR_WAIT;
      end
    endcase
  end

  // Every state change restarts the count, so a tick on the entry edge is dropped.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = 16'd0;
    end else if (tick && state_q != IDLE) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PWR_WAIT;
      cnt_q       <= 16'd0;
      idx_q       <= 3'd0;
      lcd_e_q     <= 1'b0;
      lcd_rs_q    <= 1'b0;
      lcd_data_q  <= 8'h00;
      req_ready_q <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      lcd_e_q     <= lcd_e_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_data_q  <= lcd_data_d;
      req_ready_q <= req_ready_d;
      init_done_q <= init_done_d;
    end
  end

  assign req_ready = req_ready_q;
  assign init_done = init_done_q;
  assign lcd_rs    = lcd_rs_q;
  assign lcd_rw    = 1'b0;
  assign lcd_e     = lcd_e_q;
  assign lcd_data  = lcd_data_q;

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Bench for lcd_write_sequencer: scoreboard of expected LCD writes checked by a pin-level monitor.
module tb_lcd_write_sequencer;
  localparam int P_PWR    = 4;
  localparam int P_E      = 2;
  localparam int P_CMD    = 3;
  localparam int P_CLR    = 10;
  localparam int TICK_DIV = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       req_valid;
  logic       req_rs;
  logic [7:0] req_data;
  logic       req_ready;
  logic       init_done;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_data;

  lcd_write_sequencer #(
    .POWER_TICKS(P_PWR),
    .E_TICKS    (P_E),
    .CMD_TICKS  (P_CMD),
    .CLR_TICKS  (P_CLR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .req_valid(req_valid),
    .req_rs   (req_rs),
    .req_data (req_data),
    .req_ready(req_ready),
    .init_done(init_done),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_e    (lcd_e),
    .lcd_data (lcd_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         hold;
    bit         to_idle;
  } exp_t;
  exp_t exp_q[$];

  function automatic int hold_of(input logic rs, input logic [7:0] d);
    return (!rs && d >= 8'd1 && d <= 8'd3) ? P_CLR : P_CMD;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic push_write(input logic rs, input logic [7:0] d, input bit to_idle);
    exp_t e;
    e.rs = rs; e.d = d; e.hold = hold_of(rs, d); e.to_idle = to_idle;
    exp_q.push_back(e);
  endtask

  task automatic push_init();
    logic [7:0] rom [6];
    rom = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    for (int i = 0; i < 6; i++) push_write(1'b0, rom[i], i == 5);
  endtask

  // tick: one cycle high every TICK_DIV clocks
  int tick_ph = 0;
  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick_ph = (tick_ph + 1) % TICK_DIV;
      tick = (tick_ph == 0);
    end
  end

  // Monitor: pairs each E pulse with the next expected write and times pulse and hold in ticks.
  logic       e_prev = 1'b0;
  bit         gap_active = 0;
  bit         have_cur = 0;
  bit         bus_moved;
  int         gap_cnt, e_cnt;
  logic [8:0] bus_lat;
  exp_t       cur;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        e_prev = 1'b0; gap_active = 0; have_cur = 0;
      end else begin
        if (lcd_e && !e_prev) begin
          if (gap_active) begin
            check("gap_ends_in_next_pulse", int'(cur.to_idle), 0);
            check("init_hold_plus_setup_ticks", gap_cnt, cur.hold + 1);
            gap_active = 0;
          end
          if (exp_q.size() == 0) begin
            total++; bad++; have_cur = 0;
            $display("FAIL unexpected_pulse: got rs=%0d data=0x%0h, expected no pulse", lcd_rs, lcd_data);
          end else begin
            cur = exp_q.pop_front();
            have_cur = 1;
            check("pulse_rs", int'(lcd_rs), int'(cur.rs));
            check("pulse_data", int'(lcd_data), int'(cur.d));
            check("lcd_rw_low", int'(lcd_rw), 0);
          end
          e_cnt = 0; bus_moved = 0; bus_lat = {lcd_rs, lcd_data};
        end
        if (lcd_e) begin
          if (tick) e_cnt++;
          if ({lcd_rs, lcd_data} != bus_lat) bus_moved = 1;
        end
        if (!lcd_e && e_prev) begin
          check("e_width_ticks", e_cnt, P_E);
          check("bus_stable_during_e", int'(bus_moved), 0);
          gap_active = have_cur;
          gap_cnt = 0;
        end
        if (gap_active && !lcd_e) begin
          if (req_ready) begin
            check("gap_ends_in_ready", int'(cur.to_idle), 1);
            check("hold_ticks", gap_cnt, cur.hold);
            check("init_done_with_ready", int'(init_done), 1);
            gap_active = 0;
          end else if (tick) begin
            gap_cnt++;
          end
        end
        e_prev = lcd_e;
      end
    end
  end

  task automatic wait_init();
    int n = 0;
    while (!init_done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("init_done_seen", int'(init_done), 1);
    check("ready_rises_with_init_done", int'(req_ready), 1);
    check("init_writes_consumed", exp_q.size(), 0);
  endtask

  // Called at a negedge. Holds the request until accepted, checks the bus next cycle.
  task automatic send(input logic rs, input logic [7:0] d, input bit wait_ready,
                      output int waited, output int busy_cyc);
    int busy_ticks;
    push_write(rs, d, 1'b1);
    req_rs = rs; req_data = d; req_valid = 1'b1;
    waited = 0; busy_cyc = 0;
    while (!req_ready) begin
      @(negedge clk);
      waited++;
      if (waited > 2000) begin
        total++; bad++;
        $display("FAIL accept_timeout: got no req_ready in %0d cycles, expected acceptance", waited);
        req_valid = 1'b0;
        return;
      end
    end
    @(negedge clk);
    check("accept_rs", int'(lcd_rs), int'(rs));
    check("accept_data", int'(lcd_data), int'(d));
    check("ready_drops_after_accept", int'(req_ready), 0);
    req_valid = 1'b0;
    if (wait_ready) begin
      busy_ticks = 0;
      while (!req_ready && busy_cyc < 2000) begin
        if (tick) busy_ticks++;
        busy_cyc++;
        @(negedge clk);
      end
      check("busy_ticks", busy_ticks, 1 + P_E + hold_of(rs, d));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int w, b, n;
    logic rs;
    logic [7:0] d;
    rst = 1'b1; req_valid = 1'b0; req_rs = 1'b0; req_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_lcd_e", int'(lcd_e), 0);
    check("rst_lcd_rs", int'(lcd_rs), 0);
    check("rst_lcd_rw", int'(lcd_rw), 0);
    check("rst_lcd_data", int'(lcd_data), 0);
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_init_done", int'(init_done), 0);
    rst = 1'b0;
    push_init();
    wait_init();

    // character write presented while idle
    send(1'b1, 8'h41, 1'b1, w, b);
    check("char_accept_wait", w, 0);
    // clear command
    send(1'b0, 8'h01, 1'b1, w, b);
    // back-to-back with valid held through busy
    send(1'b1, 8'h41, 1'b0, w, b);
    send(1'b1, 8'h42, 1'b1, w, b);
    check("b2b_held_through_busy", int'(w >= 20), 1);

    for (int i = 0; i < 12; i++) begin
      rs = 1'($urandom_range(0, 1));
      if (!rs && $urandom_range(0, 2) == 0) d = 8'($urandom_range(1, 3));
      else d = 8'($urandom_range(0, 255));
      send(rs, d, 1'($urandom_range(0, 1)), w, b);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // acceptance edge coincides with tick
    n = 0;
    while (!(req_ready && tick) && n < 500) begin
      @(negedge clk);
      n++;
    end
    send(1'b1, 8'h55, 1'b1, w, b);
    check("aligned_accept_wait", w, 0);
    check("aligned_busy_cycles", b, (1 + P_E + P_CMD) * TICK_DIV);

    // reset while lcd_e is high during a char write
    push_write(1'b1, 8'h5A, 1'b1);
    req_rs = 1'b1; req_data = 8'h5A; req_valid = 1'b1;
    n = 0;
    while (!lcd_e && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("e_high_before_reset", int'(lcd_e), 1);
    req_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("midrst_lcd_e", int'(lcd_e), 0);
    check("midrst_init_done", int'(init_done), 0);
    check("midrst_lcd_data", int'(lcd_data), 0);
    check("midrst_lcd_rs", int'(lcd_rs), 0);
    check("midrst_req_ready", int'(req_ready), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    push_init();
    wait_init();
    send(1'b1, 8'h42, 1'b1, w, b);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
